// File: rtl/leaf_mem_rd_arbiter_if.sv
// Leaf-memory read arbitration bus: requester handshakes, SRAM read port and tagged responses.
// burst_abort exists only when LEAF_ARB_BURST_LIMIT_EN is defined.
interface leaf_mem_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                                  req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                  req_addr;
  logic [NUM_REQ-1:0]                                  req_last;
  logic [NUM_REQ-1:0]                                  req_ready;
  logic                                                mem_csb;
  logic [ADDR_WIDTH-1:0]                               mem_addr;
  logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] mem_rdata;
  logic                                                rsp_valid;
  logic [ID_WIDTH-1:0]                                 rsp_id;
  logic                                                rsp_last;
  logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] rsp_data;
  logic                                                busy;
`ifdef LEAF_ARB_BURST_LIMIT_EN
  logic                                                burst_abort;
`endif

  modport slave (
    input  req_valid, req_addr, req_last, mem_rdata,
    output req_ready, mem_csb, mem_addr, rsp_valid, rsp_id, rsp_last, rsp_data, busy
`ifdef LEAF_ARB_BURST_LIMIT_EN
    , output burst_abort
`endif
  );

  modport master (
    output req_valid, req_addr, req_last, mem_rdata,
    input  req_ready, mem_csb, mem_addr, rsp_valid, rsp_id, rsp_last, rsp_data, busy
`ifdef LEAF_ARB_BURST_LIMIT_EN
    , input burst_abort
`endif
  );
endinterface

// File: rtl/leaf_mem_rd_arbiter.sv
// Round-robin leaf-SRAM read arbiter with burst lock; grant and SRAM read issue in the accept cycle, response RD_LATENCY later.
// Non-owners are held off via req_ready; responses cannot be stalled. LEAF_ARB_BURST_LIMIT_EN caps bursts at MAX_BURST beats.
module leaf_mem_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_LEAVES),
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  leaf_mem_rd_arbiter_if.slave  arb_if
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int PID_W = RD_LATENCY * ID_W;

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                          state_q, state_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                 owner_q, owner_d;
  logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [RD_LATENCY-1:0]           vld_q, last_q;
  logic [RD_LATENCY-1:0][ID_W-1:0] id_q;

  logic [NUM_REQ-1:0]    ready;
  logic                  csb;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  acc;
  logic [ID_W-1:0]       acc_id;
  logic                  acc_last;
  logic                  found;
  logic [ID_W-1:0]       win;
  logic [ID_W-1:0]       cand;
`ifdef LEAF_ARB_BURST_LIMIT_EN
  logic                  abort;
`endif

  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + ID_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    ready      = '0;
    csb        = 1'b1;
    addr       = '0;
    acc        = 1'b0;
    acc_id     = '0;
    acc_last   = 1'b0;
    found      = 1'b0;
    win        = rr_ptr_q;
    cand       = '0;
`ifdef LEAF_ARB_BURST_LIMIT_EN
    abort      = 1'b0;
`endif
    // First valid requester at or after rr_ptr, wrapping.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && arb_if.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    // Nothing is accepted while reset is held so no read escapes into the SRAM.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            ready[win] = 1'b1;
            acc        = 1'b1;
            acc_id     = win;
            acc_last   = arb_if.req_last[win];
            csb        = 1'b0;
            addr       = arb_if.req_addr[win];
            if (arb_if.req_last[win]) begin
              rr_ptr_d = nxt(win);
            end else begin
              state_d    = BURST;
              owner_d    = win;
              beat_cnt_d = CNT_W'(1);
            end
          end
        end
        BURST: begin
          ready[owner_q] = 1'b1;
          if (arb_if.req_valid[owner_q]) begin
            acc      = 1'b1;
            acc_id   = owner_q;
            acc_last = arb_if.req_last[owner_q];
            csb      = 1'b0;
            addr     = arb_if.req_addr[owner_q];
            if (arb_if.req_last[owner_q]) begin
              state_d    = IDLE;
              rr_ptr_d   = nxt(owner_q);
              beat_cnt_d = '0;
            end
`ifdef LEAF_ARB_BURST_LIMIT_EN
            else if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
              acc_last   = 1'b1;
              abort      = 1'b1;
              state_d    = IDLE;
              rr_ptr_d   = nxt(owner_q);
              beat_cnt_d = '0;
            end
`endif
            else begin
              beat_cnt_d = (beat_cnt_q == CNT_W'(MAX_BURST)) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      vld_q      <= '0;
      last_q     <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      // Tag shift register mirrors the SRAM read latency.
      vld_q      <= (vld_q << 1) | RD_LATENCY'(acc);
      last_q     <= (last_q << 1) | RD_LATENCY'(acc_last);
      id_q       <= (id_q << ID_W) | PID_W'(acc_id);
    end
  end

  assign arb_if.req_ready = ready;
  assign arb_if.mem_csb   = csb;
  assign arb_if.mem_addr  = addr;
  assign arb_if.rsp_valid = vld_q[RD_LATENCY-1];
  assign arb_if.rsp_last  = last_q[RD_LATENCY-1];
  assign arb_if.rsp_id    = id_q[RD_LATENCY-1];
  assign arb_if.rsp_data  = arb_if.mem_rdata;
  assign arb_if.busy      = (state_q == BURST);
`ifdef LEAF_ARB_BURST_LIMIT_EN
  assign arb_if.burst_abort = abort;
`endif
endmodule

// File: tb/tb_leaf_mem_rd_arbiter.sv
// Directed bench for leaf_mem_rd_arbiter: default instance plus an RD_LATENCY=2, MAX_BURST=4 instance.
module tb_leaf_mem_rd_arbiter;
  localparam int NR = 4, AW = 6, DW = 11, PS = 5, LS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [LS*PS*DW-1:0] rdata_pat;

  always #5 clk = ~clk;

  leaf_mem_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS)) bus ();
  leaf_mem_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS)) bus2 ();

  leaf_mem_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS), .NUM_LEAVES(64))
    dut (.clk(clk), .rst(rst), .arb_if(bus));
  leaf_mem_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS), .NUM_LEAVES(64),
                        .RD_LATENCY(2), .MAX_BURST(4))
    dut2 (.clk(clk), .rst(rst), .arb_if(bus2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.busy}
        !== {4'b0000, 1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.busy},
               {4'b0000, 1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req_addr[0] = 6'd5;
    bus.req_last    = 4'b0001;
    bus.req_valid   = 4'b0001;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid} !== {4'b0001, 1'b0, 6'd5, 1'b0}) begin
      errors++;
      $display("FAIL single_accept: got %h want %h", {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid},
               {4'b0001, 1'b0, 6'd5, 1'b0});
    end
    cyc();
    bus.req_valid = '0;
    #2;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.mem_csb, bus.busy} !== {1'b1, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.mem_csb, bus.busy},
               {1'b1, 2'd0, 1'b1, 1'b1, 1'b0});
    end
    checks++;
    if (bus.rsp_data !== rdata_pat) begin
      errors++;
      $display("FAIL rsp_data: got %h want %h", bus.rsp_data, rdata_pat);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd1) begin
      errors++;
      $display("FAIL single_rr_ptr: got %0d want 1", dut.rr_ptr_q);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    int e;
    int prev;
    for (int i = 0; i < NR; i++) bus.req_addr[i] = 6'(20 + i);
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      e       = (1 + k) % NR;
      exp_rdy = 4'(1 << e);
      checks++;
      if ({bus.req_ready, bus.mem_csb, bus.mem_addr} !== {exp_rdy, 1'b0, 6'(20 + e)}) begin
        errors++;
        $display("FAIL rr_grant%0d: got %h want %h", k, {bus.req_ready, bus.mem_csb, bus.mem_addr},
                 {exp_rdy, 1'b0, 6'(20 + e)});
      end
      if (k > 0) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_last} !== {1'b1, 2'(prev), 1'b1}) begin
          errors++;
          $display("FAIL rr_rsp%0d: got %h want %h", k, {bus.rsp_valid, bus.rsp_id, bus.rsp_last},
                   {1'b1, 2'(prev), 1'b1});
        end
      end
      prev = e;
      cyc();
    end
    bus.req_valid = '0;
    #2;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.mem_csb} !== {1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL rr_tail: got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.mem_csb}, {1'b1, 2'd2, 1'b1});
    end
    cyc();
  endtask

  task automatic test_burst_lock();
    bus.req_addr[2] = 6'd10;
    bus.req_last    = 4'b0000;
    bus.req_valid   = 4'b0100;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy} !== {4'b0100, 1'b0, 6'd10, 1'b0}) begin
      errors++;
      $display("FAIL burst_beat1: got %h want %h", {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy},
               {4'b0100, 1'b0, 6'd10, 1'b0});
    end
    cyc();
    bus.req_addr[0] = 6'd1;
    bus.req_addr[1] = 6'd2;
    bus.req_last    = 4'b0011;
    bus.req_valid   = 4'b0111;
    for (int b = 1; b < 4; b++) begin
      bus.req_addr[2] = 6'(10 + b);
      if (b == 3) bus.req_last = 4'b0111;
      #2;
      checks++;
      if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last}
          !== {4'b0100, 1'b0, 6'(10 + b), 1'b1, 1'b1, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL burst_beat%0d: got %h want %h", b + 1,
                 {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last},
                 {4'b0100, 1'b0, 6'(10 + b), 1'b1, 1'b1, 2'd2, 1'b0});
      end
      cyc();
    end
    bus.req_valid = 4'b0011;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last}
        !== {4'b0001, 6'd1, 1'b0, 1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL burst_release: got %h want %h",
               {bus.req_ready, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last},
               {4'b0001, 6'd1, 1'b0, 1'b1, 2'd2, 1'b1});
    end
    cyc();
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_addr, bus.rsp_id, bus.rsp_last} !== {4'b0010, 6'd2, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL burst_next: got %h want %h", {bus.req_ready, bus.mem_addr, bus.rsp_id, bus.rsp_last},
               {4'b0010, 6'd2, 2'd0, 1'b1});
    end
    cyc();
    bus.req_valid = '0;
    bus.req_last  = '0;
  endtask

  task automatic test_bubble();
    bus.req_addr[1] = 6'd30;
    bus.req_valid   = 4'b0010;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr} !== {4'b0010, 1'b0, 6'd30}) begin
      errors++;
      $display("FAIL bubble_start: got %h want %h", {bus.req_ready, bus.mem_csb, bus.mem_addr}, {4'b0010, 1'b0, 6'd30});
    end
    cyc();
    bus.req_addr[1] = 6'd31;
    bus.req_addr[0] = 6'd40;
    bus.req_addr[3] = 6'd41;
    bus.req_valid   = 4'b1011;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy} !== {4'b0010, 1'b0, 6'd31, 1'b1}) begin
      errors++;
      $display("FAIL bubble_beat2: got %h want %h", {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.busy},
               {4'b0010, 1'b0, 6'd31, 1'b1});
    end
    cyc();
    bus.req_valid = 4'b1001;
    for (int g = 0; g < 2; g++) begin
      #2;
      checks++;
      if ({bus.req_ready, bus.mem_csb, bus.busy, bus.rsp_valid} !== {4'b0010, 1'b1, 1'b1, (g == 0)}) begin
        errors++;
        $display("FAIL bubble_gap%0d: got %h want %h", g, {bus.req_ready, bus.mem_csb, bus.busy, bus.rsp_valid},
                 {4'b0010, 1'b1, 1'b1, (g == 0)});
      end
      checks++;
      if (dut.beat_cnt_q !== 7'd2) begin
        errors++;
        $display("FAIL bubble_cnt%0d: got %0d want 2", g, dut.beat_cnt_q);
      end
      cyc();
    end
    bus.req_addr[1] = 6'd32;
    bus.req_last    = 4'b1010;
    bus.req_valid   = 4'b1011;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid} !== {4'b0010, 1'b0, 6'd32, 1'b0}) begin
      errors++;
      $display("FAIL bubble_resume: got %h want %h", {bus.req_ready, bus.mem_csb, bus.mem_addr, bus.rsp_valid},
               {4'b0010, 1'b0, 6'd32, 1'b0});
    end
    cyc();
    bus.req_valid = 4'b1001;
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last}
        !== {4'b1000, 6'd41, 1'b0, 1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL bubble_end: got %h want %h",
               {bus.req_ready, bus.mem_addr, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_last},
               {4'b1000, 6'd41, 1'b0, 1'b1, 2'd1, 1'b1});
    end
    cyc();
    bus.req_valid = '0;
    bus.req_last  = '0;
    cyc();
  endtask

  task automatic test_reset_midburst();
    bus2.req_addr[0] = 6'd7;
    bus2.req_addr[1] = 6'd8;
    bus2.req_last    = 4'b0000;
    bus2.req_valid   = 4'b0001;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.busy} !== {4'b0001, 1'b0, 6'd7, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_accept: got %h want %h", {bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.busy},
               {4'b0001, 1'b0, 6'd7, 1'b0});
    end
    cyc();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_csb, bus2.busy, bus2.rsp_valid} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_clear: got %h want %h", {bus2.req_ready, bus2.mem_csb, bus2.busy, bus2.rsp_valid},
               {4'b0000, 1'b1, 1'b0, 1'b0});
    end
    cyc();
    #2;
    checks++;
    if (bus2.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold: got rsp_valid %b want 0", bus2.rsp_valid);
    end
    cyc();
    rst = 1'b0;
    bus2.req_last  = 4'b0011;
    bus2.req_valid = 4'b0011;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.busy, bus2.rsp_valid} !== {4'b0001, 1'b0, 6'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_regrant: got %h want %h",
               {bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.busy, bus2.rsp_valid},
               {4'b0001, 1'b0, 6'd7, 1'b0, 1'b0});
    end
    cyc();
    bus2.req_valid = '0;
    bus2.req_last  = '0;
    #2;
    checks++;
    if ({bus2.rsp_valid, bus2.busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_nospur: got %b want 00", {bus2.rsp_valid, bus2.busy});
    end
    cyc();
    #2;
    checks++;
    if ({bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_lat2: got %h want %h", {bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last}, {1'b1, 2'd0, 1'b1});
    end
    cyc();
    #2;
    checks++;
    if (bus2.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain: got rsp_valid %b want 0", bus2.rsp_valid);
    end
    cyc();
  endtask

`ifdef LEAF_ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    bus2.req_addr[1] = 6'd50;
    bus2.req_addr[2] = 6'd60;
    bus2.req_last    = 4'b0000;
    bus2.req_valid   = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      bus2.req_addr[1] = 6'(50 + b);
      if (b == 1) begin
        bus2.req_last  = 4'b0100;
        bus2.req_valid = 4'b0110;
      end
      #2;
      checks++;
      if ({bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.burst_abort} !== {4'b0010, 1'b0, 6'(50 + b), (b == 3)}) begin
        errors++;
        $display("FAIL limit_beat%0d: got %h want %h", b + 1,
                 {bus2.req_ready, bus2.mem_csb, bus2.mem_addr, bus2.burst_abort}, {4'b0010, 1'b0, 6'(50 + b), (b == 3)});
      end
      cyc();
    end
    bus2.req_addr[1] = 6'd54;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_addr, bus2.burst_abort, bus2.busy, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last}
        !== {4'b0100, 6'd60, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL limit_other: got %h want %h",
               {bus2.req_ready, bus2.mem_addr, bus2.burst_abort, bus2.busy, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last},
               {4'b0100, 6'd60, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0});
    end
    cyc();
    bus2.req_valid = 4'b0010;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_addr, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last} !== {4'b0010, 6'd54, 1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL limit_forced_last: got %h want %h",
               {bus2.req_ready, bus2.mem_addr, bus2.rsp_valid, bus2.rsp_id, bus2.rsp_last},
               {4'b0010, 6'd54, 1'b1, 2'd1, 1'b1});
    end
    cyc();
    bus2.req_addr[1] = 6'd55;
    bus2.req_last    = 4'b0010;
    #2;
    checks++;
    if ({bus2.req_ready, bus2.mem_addr, bus2.busy, bus2.rsp_id, bus2.rsp_last} !== {4'b0010, 6'd55, 1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL limit_resume: got %h want %h", {bus2.req_ready, bus2.mem_addr, bus2.busy, bus2.rsp_id, bus2.rsp_last},
               {4'b0010, 6'd55, 1'b1, 2'd2, 1'b1});
    end
    cyc();
    bus2.req_valid = '0;
    bus2.req_last  = '0;
    cyc();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rdata_pat      = {14{32'hA5C3_0F96}};
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_last   = '0;
    bus.mem_rdata  = rdata_pat;
    bus2.req_valid = '0;
    bus2.req_addr  = '0;
    bus2.req_last  = '0;
    bus2.mem_rdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_burst_lock();
    test_bubble();
    test_reset_midburst();
`ifdef LEAF_ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
